// File: rtl/vx_icache_rsp_pkg.sv
// Shared widths, sizing helpers and the response entry layout for the
// icache response buffer.
package vx_icache_rsp_pkg;

   function automatic int word_width(input int word_size);
      return 8 * word_size;
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DEF_WORD_SIZE  = 4;
   localparam int DEF_TAG_WIDTH  = 1;
   localparam int DEF_WORD_WIDTH = word_width(DEF_WORD_SIZE);

   typedef struct packed {
      logic [DEF_WORD_WIDTH-1:0] data;
      logic [DEF_TAG_WIDTH-1:0]  tag;
   } icache_rsp_entry_t;

endpackage

// File: rtl/vx_rsp_fifo_mem.sv
// DEPTH x ENTRY_W flop array: one synchronous write port, one asynchronous
// read port, whole array cleared by the asynchronous reset.
module vx_rsp_fifo_mem
   import vx_icache_rsp_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter int  ENTRY_W = 33,
   localparam int ADDR_W  = ptr_w(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem_r [DEPTH];

   // Storage write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/vx_icache_rsp_buffer.sv
// Elastic in-order queue between the icache response port and fetch/decode.
// Every output is driven from flops so decode back-pressure never reaches the cache.
module vx_icache_rsp_buffer
   import vx_icache_rsp_pkg::*;
#(
   parameter int  WORD_SIZE  = 4,
   parameter int  TAG_WIDTH  = 1,
   parameter int  DEPTH      = 4,
   localparam int WORD_WIDTH = word_width(WORD_SIZE),
   localparam int PTR_W      = ptr_w(DEPTH),
   localparam int CNT_W      = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rsp_valid_in,
   input  logic [WORD_WIDTH-1:0] rsp_data_in,
   input  logic [TAG_WIDTH-1:0]  rsp_tag_in,
   output logic                  rsp_ready_in,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0]  out_tag,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      count
);

   typedef struct packed {
      logic [WORD_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  tag;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  ready_r;
   logic [WORD_WIDTH-1:0] out_data_r;
   logic [TAG_WIDTH-1:0]  out_tag_r;

   logic                  push_s;
   logic                  pop_s;
   logic [PTR_W-1:0]      rd_next_s;
   logic [PTR_W-1:0]      wr_next_s;
   logic [CNT_W-1:0]      count_next_s;
   logic                  bypass_s;
   logic                  head_load_s;
   entry_t                wr_entry_s;
   entry_t                rd_entry_s;
   entry_t                head_s;

   assign out_valid    = (count_r != '0);
   assign rsp_ready_in = ready_r;
   assign count        = count_r;
   assign out_data     = out_data_r;
   assign out_tag      = out_tag_r;

   assign push_s     = rsp_valid_in & ready_r & ~flush;
   assign pop_s      = out_valid & out_ready & ~flush;
   assign wr_entry_s = '{data: rsp_data_in, tag: rsp_tag_in};

   // Next pointers/count and the value the head register takes next.
   always_comb begin
      rd_next_s    = rd_ptr_r;
      wr_next_s    = wr_ptr_r;
      count_next_s = count_r;
      bypass_s     = 1'b0;
      head_load_s  = 1'b0;
      head_s       = rd_entry_s;
      if (flush) begin
         rd_next_s    = '0;
         wr_next_s    = '0;
         count_next_s = '0;
      end else begin
         rd_next_s = pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
         wr_next_s = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
         if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
         end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
         end else begin
            count_next_s = count_r;
         end
         // The pushed word becomes the head when nothing older survives this edge.
         bypass_s = push_s && (count_r == (pop_s ? CNT_W'(1) : CNT_W'(0)));
         if (bypass_s) begin
            head_load_s = 1'b1;
            head_s      = wr_entry_s;
         end else if (count_next_s != '0) begin
            head_load_s = 1'b1;
            head_s      = rd_entry_s;
         end else begin
            head_load_s = 1'b0;
            head_s      = rd_entry_s;
         end
      end
   end

   vx_rsp_fifo_mem #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (wr_entry_s),
      .raddr (rd_next_s),
      .rdata (rd_entry_s)
   );

   // Pointer, occupancy, ready flag and head register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
         ready_r    <= 1'b0;
         out_data_r <= '0;
         out_tag_r  <= '0;
      end else begin
         rd_ptr_r <= rd_next_s;
         wr_ptr_r <= wr_next_s;
         count_r  <= count_next_s;
         ready_r  <= (count_next_s != CNT_W'(DEPTH));
         if (head_load_s) begin
            out_data_r <= head_s.data;
            out_tag_r  <= head_s.tag;
         end else begin
            out_data_r <= out_data_r;
            out_tag_r  <= out_tag_r;
         end
      end
   end

endmodule

// File: tb/tb_vx_icache_rsp_buffer.sv
// Directed and randomized self-checking bench for vx_icache_rsp_buffer
// (default DEPTH=4, 32-bit word, 1-bit tag).
module tb_vx_icache_rsp_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        rsp_valid_in;
   logic [31:0] rsp_data_in;
   logic [0:0]  rsp_tag_in;
   logic        rsp_ready_in;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_data;
   logic [0:0]  out_tag;
   logic        out_ready;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   vx_icache_rsp_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .rsp_valid_in (rsp_valid_in),
      .rsp_data_in  (rsp_data_in),
      .rsp_tag_in   (rsp_tag_in),
      .rsp_ready_in (rsp_ready_in),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_tag      (out_tag),
      .out_ready    (out_ready),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; rsp_valid_in = 1'b0; rsp_data_in = 32'h0; rsp_tag_in = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      #1 reset = 1'b1;
      #2;
      checks++; if (rsp_ready_in !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", rsp_ready_in); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_data !== 32'h0 || out_tag !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%0b exp=0/0", out_data, out_tag); end
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++; if (rsp_ready_in !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", rsp_ready_in); end
   endtask

   task automatic test_single();
      rsp_valid_in = 1'b1; rsp_data_in = 32'hDEADBEEF; rsp_tag_in = 1'b1; out_ready = 1'b1;
      step();
      rsp_valid_in = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_tag !== 1'b1) begin
         failures++; $display("FAIL single_head got=%0b/%h/%0b exp=1/deadbeef/1", out_valid, out_data, out_tag); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
      step();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0d/%0b exp=0/0", count, out_valid); end
      checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%h exp=deadbeef", out_data); end
      out_ready = 1'b0;
   endtask

   task automatic test_fill();
      logic [31:0] words [4];
      words[0] = 32'hA0A0_0000; words[1] = 32'hA1A1_1111; words[2] = 32'hA2A2_2222; words[3] = 32'hA3A3_3333;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rsp_valid_in = 1'b1; rsp_data_in = words[i]; rsp_tag_in = 1'(i);
         step();
      end
      checks++; if (rsp_ready_in !== 1'b0 || count !== 3'd4) begin failures++; $display("FAIL fill_full got=%0b/%0d exp=0/4", rsp_ready_in, count); end
      checks++; if (out_data !== words[0] || out_tag !== 1'b0) begin failures++; $display("FAIL fill_head got=%h exp=%h", out_data, words[0]); end
      rsp_valid_in = 1'b1; rsp_data_in = 32'h5555_5555; rsp_tag_in = 1'b1; out_ready = 1'b1;
      step();
      rsp_valid_in = 1'b0;
      checks++; if (count !== 3'd3 || rsp_ready_in !== 1'b1) begin failures++; $display("FAIL fill_pop_no_push got=%0d/%0b exp=3/1", count, rsp_ready_in); end
      for (int i = 1; i < 4; i++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== words[i] || out_tag !== 1'(i)) begin
            failures++; $display("FAIL fill_order%0d got=%0b/%h/%0b exp=1/%h/%0b", i, out_valid, out_data, out_tag, words[i], 1'(i)); end
         step();
      end
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0d/%0b exp=0/0", count, out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rsp_valid_in = 1'b1; rsp_data_in = 32'hC000_0000 + 32'(k); rsp_tag_in = 1'(k);
         step();
         checks++; if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 + 32'(k) || out_tag !== 1'(k) || count !== 3'd1) begin
            failures++; $display("FAIL stream%0d got=%0b/%h/%0b/%0d exp=1/%h/%0b/1", k, out_valid, out_data, out_tag, count,
                                 32'hC000_0000 + 32'(k), 1'(k)); end
      end
      rsp_valid_in = 1'b0;
      step();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_drain got=%0d exp=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [32:0] q [$];
      logic [32:0] held;
      logic        stalled;
      logic        do_push;
      logic        do_pop;
      stalled = 1'b0;
      held    = '0;
      for (int c = 0; c < 1000; c++) begin
         checks++; if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) || rsp_ready_in !== (q.size() < 4)) begin
            failures++; $display("FAIL rand_state cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", c, count, out_valid, rsp_ready_in,
                                 q.size(), q.size() != 0, q.size() < 4); end
         if (q.size() != 0) begin
            checks++; if ({out_data, out_tag} !== q[0]) begin
               failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, {out_data, out_tag}, q[0]); end
         end
         if (stalled) begin
            checks++; if ({out_data, out_tag} !== held) begin
               failures++; $display("FAIL rand_stable cyc=%0d got=%h exp=%h", c, {out_data, out_tag}, held); end
         end
         rsp_valid_in = 1'($urandom_range(0, 1));
         out_ready    = ($urandom_range(0, 2) != 0);
         rsp_data_in  = $urandom;
         rsp_tag_in   = 1'($urandom_range(0, 1));
         do_push = rsp_valid_in && (q.size() < 4);
         do_pop  = out_ready && (q.size() != 0);
         stalled = (q.size() != 0) && !out_ready;
         held    = {out_data, out_tag};
         step();
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({rsp_data_in, rsp_tag_in});
      end
      rsp_valid_in = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL rand_drain got=%0d exp=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rsp_valid_in = 1'b1; rsp_data_in = 32'hF000_0000 + 32'(i); rsp_tag_in = 1'b0;
         step();
      end
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", count); end
      rsp_valid_in = 1'b1; rsp_data_in = 32'hBAD0_BAD0; rsp_tag_in = 1'b1; out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; rsp_valid_in = 1'b0;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || rsp_ready_in !== 1'b1) begin
         failures++; $display("FAIL flush_clear got=%0d/%0b/%0b exp=0/0/1", count, out_valid, rsp_ready_in); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stays_empty got=%0b exp=0", out_valid); end
      rsp_valid_in = 1'b1; rsp_data_in = 32'h0000_1234; rsp_tag_in = 1'b0; out_ready = 1'b0;
      step();
      rsp_valid_in = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || count !== 3'd1) begin
         failures++; $display("FAIL flush_refill got=%0b/%h/%0d exp=1/00001234/1", out_valid, out_data, count); end
      out_ready = 1'b1;
      step();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_refill_drain got=%0d exp=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rsp_valid_in = 1'b1; rsp_data_in = 32'hE000_0000 + 32'(i); rsp_tag_in = 1'b1;
         step();
      end
      rsp_valid_in = 1'b0;
      checks++; if (count !== 3'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0d/%0b exp=2/1", count, out_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0 || rsp_ready_in !== 1'b0) begin
         failures++; $display("FAIL areset_immediate got=%0b/%0d/%0b exp=0/0/0", out_valid, count, rsp_ready_in); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++; if (rsp_ready_in !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
         failures++; $display("FAIL areset_release got=%0b/%0b/%0d exp=1/0/0", rsp_ready_in, out_valid, count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_random();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
